// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Byte FIFO in front of a UART transmitter. Bytes written on i_fWr
//            are queued in a DEPTH-entry circular buffer and launched one at a
//            time to the transmitter with a registered one-cycle o_fTx pulse,
//            paced by the transmitter's ready flag and stop-bit-done pulse.
// Ports    : i_Clk       clock, rising edge
//            i_Rst       reset, asynchronous, active-low
//            i_fWr       write strobe (one byte per high cycle)
//            i_WrData    byte to enqueue
//            i_fClrOvf   synchronous clear of overflow status
//            i_fTxReady  transmitter idle
//            i_fTxDone   transmitter stop-bit-complete pulse
//            o_fTx       one-cycle launch pulse to transmitter
//            o_TxData    launched byte, held until the next launch
//            o_fFull     count == DEPTH
//            o_fEmpty    count == 0
//            o_Count     bytes stored, 0..DEPTH
//            o_fOvf      sticky: a write was dropped
//            o_fBusy     launch state machine not idle
//            o_OvfCnt    saturating dropped-write count (optional, see below)
// Options  : UART_TX_FIFO_OVF_CNT_EN -- when defined, adds o_OvfCnt.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 16,   // power of two, 2..256
    parameter int AW    = 4     // log2(DEPTH)
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic          i_fWr,
    input  logic [7:0]    i_WrData,
    input  logic          i_fClrOvf,
    input  logic          i_fTxReady,
    input  logic          i_fTxDone,
    output logic          o_fTx,
    output logic [7:0]    o_TxData,
    output logic          o_fFull,
    output logic          o_fEmpty,
    output logic [AW:0]   o_Count,
    output logic          o_fOvf,
    output logic          o_fBusy
`ifdef UART_TX_FIFO_OVF_CNT_EN
    ,
    output logic [7:0]    o_OvfCnt
`endif
);

    localparam logic [AW:0] c_Depth = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2
    } state_t;

    state_t         r_State;
    state_t         w_NextState;

    logic [7:0]     r_Mem [DEPTH];
    logic [AW-1:0]  r_WrPtr;
    logic [AW-1:0]  r_RdPtr;
    logic [AW:0]    r_Count;
    logic           r_fTx;
    logic [7:0]     r_TxData;
    logic           r_fOvf;

    logic           w_Full;
    logic           w_Empty;
    logic           w_Pop;
    logic           w_WrAcc;
    logic           w_Drop;

    // Status comes only from the registered count, never from i_fWr.
    assign w_Full  = (r_Count == c_Depth);
    assign w_Empty = (r_Count == '0);

    // A full FIFO still takes a write when the head leaves in the same cycle.
    // An empty FIFO never pops, so write+pop on empty is simply a write.
    assign w_WrAcc = i_fWr && (!w_Full || w_Pop);
    assign w_Drop  = i_fWr && w_Full && !w_Pop;

    // ------------------------------------------------------------------
    // Launch state machine
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_State <= S_IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    always_comb begin
        w_NextState = r_State;
        w_Pop       = 1'b0;
        case (r_State)
            S_IDLE: begin
                if (i_fTxReady && !w_Empty) begin
                    w_Pop       = 1'b1;
                    w_NextState = S_LAUNCH;
                end
            end
            // Wait for the transmitter to acknowledge by dropping ready, so a
            // stale ready flag cannot trigger a second launch.
            S_LAUNCH: begin
                if (!i_fTxReady) begin
                    w_NextState = S_BUSY;
                end
            end
            S_BUSY: begin
                if (i_fTxDone) begin
                    w_NextState = S_IDLE;
                end
            end
            default: begin
                w_NextState = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: not reset, contents are only meaningful below r_Count.
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (w_WrAcc) begin
            r_Mem[r_WrPtr] <= i_WrData;
        end
    end

    // Pointers wrap naturally because DEPTH == 2**AW.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_WrPtr <= '0;
            r_RdPtr <= '0;
            r_Count <= '0;
        end else begin
            if (w_WrAcc) begin
                r_WrPtr <= r_WrPtr + 1'b1;
            end
            if (w_Pop) begin
                r_RdPtr <= r_RdPtr + 1'b1;
            end
            if (w_WrAcc && !w_Pop) begin
                r_Count <= r_Count + 1'b1;
            end else if (!w_WrAcc && w_Pop) begin
                r_Count <= r_Count - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Launch outputs. The head is read before any same-cycle write to the
    // same slot lands, so a write-while-full cannot overtake the head.
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_fTx    <= 1'b0;
            r_TxData <= 8'hFF;
        end else begin
            r_fTx <= w_Pop;
            if (w_Pop) begin
                r_TxData <= r_Mem[r_RdPtr];
            end
        end
    end

    // Overflow flag: a drop in the same cycle as a clear wins.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_fOvf <= 1'b0;
        end else if (w_Drop) begin
            r_fOvf <= 1'b1;
        end else if (i_fClrOvf) begin
            r_fOvf <= 1'b0;
        end
    end

`ifdef UART_TX_FIFO_OVF_CNT_EN
    logic [7:0] r_OvfCnt;

    // Saturating drop counter; an increment (or a saturated drop) beats clear.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_OvfCnt <= 8'd0;
        end else if (w_Drop) begin
            if (r_OvfCnt != 8'hFF) begin
                r_OvfCnt <= r_OvfCnt + 8'd1;
            end
        end else if (i_fClrOvf) begin
            r_OvfCnt <= 8'd0;
        end
    end

    assign o_OvfCnt = r_OvfCnt;
`endif

    assign o_fTx    = r_fTx;
    assign o_TxData = r_TxData;
    assign o_fFull  = w_Full;
    assign o_fEmpty = w_Empty;
    assign o_Count  = r_Count;
    assign o_fOvf   = r_fOvf;
    assign o_fBusy  = (r_State != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo. Stimulus pushes accepted
//            bytes into an expected queue; a monitor pops and compares on
//            every o_fTx pulse and tracks count/overflow status each cycle.
//            A behavioural transmitter drives ready/done.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          i_Rst = 1'b0;
    logic          i_fWr = 1'b0;
    logic [7:0]    i_WrData = 8'h00;
    logic          i_fClrOvf = 1'b0;
    logic          i_fTxReady = 1'b1;
    logic          i_fTxDone = 1'b0;
    logic          o_fTx;
    logic [7:0]    o_TxData;
    logic          o_fFull;
    logic          o_fEmpty;
    logic [AW:0]   o_Count;
    logic          o_fOvf;
    logic          o_fBusy;
`ifdef UART_TX_FIFO_OVF_CNT_EN
    logic [7:0]    o_OvfCnt;
`endif

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_Clk      (clk),
        .i_Rst      (i_Rst),
        .i_fWr      (i_fWr),
        .i_WrData   (i_WrData),
        .i_fClrOvf  (i_fClrOvf),
        .i_fTxReady (i_fTxReady),
        .i_fTxDone  (i_fTxDone),
        .o_fTx      (o_fTx),
        .o_TxData   (o_TxData),
        .o_fFull    (o_fFull),
        .o_fEmpty   (o_fEmpty),
        .o_Count    (o_Count),
        .o_fOvf     (o_fOvf),
        .o_fBusy    (o_fBusy)
`ifdef UART_TX_FIFO_OVF_CNT_EN
        ,
        .o_OvfCnt   (o_OvfCnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [7:0] expQ[$];     // bytes accepted, in order of transmission
    int         mCount = 0;  // bytes the FIFO should hold
    bit         mOvf = 0;
    int         mOvfCnt = 0;
    bit         pendAcc = 0, pendDrop = 0, pendClr = 0;

    int nChecks = 0;
    int nErrors = 0;
    int nLaunch = 0;

    // ---------------- transmitter model state ----------------
    bit txBusy = 0;
    int txCnt = 0;
    bit hold = 0;            // force ready low (transmitter held off)
    bit randBits = 0;
    int bitTime = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitter: drops ready the cycle after a launch, holds it low for
    // 10 bit times, then pulses done and returns to ready.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!i_Rst) begin
                txBusy = 0; txCnt = 0; i_fTxDone = 0;
            end else begin
                i_fTxDone = 0;
                if (o_fTx) begin
                    txBusy = 1;
                    if (randBits) bitTime = $urandom_range(1, 3);
                    txCnt = 10 * bitTime;
                end else if (txBusy) begin
                    if (txCnt > 1) txCnt--;
                    else begin
                        txBusy = 0;
                        i_fTxDone = 1;
                    end
                end
            end
            i_fTxReady = !txBusy && !hold;
        end
    end

    // Monitor / scoreboard: observes the state after each rising edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (i_Rst) begin
                if (pendAcc) mCount++;
                if (o_fTx) begin
                    nLaunch++;
                    check("launch_while_tx_busy", {31'd0, txBusy}, 32'd0);
                    if (expQ.size() == 0) begin
                        check("unexpected_launch", 32'd1, 32'd0);
                    end else begin
                        e = expQ.pop_front();
                        check("tx_data", {24'd0, o_TxData}, {24'd0, e});
                        mCount--;
                    end
                end
                if (pendDrop) mOvf = 1;
                else if (pendClr) mOvf = 0;
                if (pendDrop) begin
                    if (mOvfCnt < 255) mOvfCnt++;
                end else if (pendClr) mOvfCnt = 0;
                check("count", 32'(o_Count), 32'(mCount));
                check("empty", {31'd0, o_fEmpty}, {31'd0, mCount == 0});
                check("full", {31'd0, o_fFull}, {31'd0, mCount == DEPTH});
                check("ovf", {31'd0, o_fOvf}, {31'd0, mOvf});
`ifdef UART_TX_FIFO_OVF_CNT_EN
                check("ovf_cnt", {24'd0, o_OvfCnt}, 32'(mOvfCnt));
`endif
                if (txBusy) check("busy_during_tx", {31'd0, o_fBusy}, 32'd1);
                pendAcc = 0; pendDrop = 0; pendClr = 0;
            end
        end
    end

    // One stimulus cycle. A full FIFO frees a slot this cycle exactly when
    // the transmitter shows ready without a done pulse (launch idle state).
    task automatic drive(input bit wr, input logic [7:0] d, input bit clr);
        bit canPop, acc;
        @(negedge clk);
        #3;
        canPop = i_fTxReady && !i_fTxDone && (mCount > 0);
        acc = wr && ((mCount < DEPTH) || canPop);
        if (acc) expQ.push_back(d);
        pendAcc = acc;
        pendDrop = wr && !acc;
        pendClr = clr;
        i_fWr = wr;
        i_WrData = d;
        i_fClrOvf = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 8'h00, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        i_Rst = 0; i_fWr = 0; i_fClrOvf = 0;
        expQ.delete();
        mCount = 0; mOvf = 0; mOvfCnt = 0;
        pendAcc = 0; pendDrop = 0; pendClr = 0;
        #1;
        check("rst_fTx", {31'd0, o_fTx}, 32'd0);
        check("rst_TxData", {24'd0, o_TxData}, 32'hFF);
        check("rst_empty", {31'd0, o_fEmpty}, 32'd1);
        check("rst_full", {31'd0, o_fFull}, 32'd0);
        check("rst_count", 32'(o_Count), 32'd0);
        check("rst_busy", {31'd0, o_fBusy}, 32'd0);
        check("rst_ovf", {31'd0, o_fOvf}, 32'd0);
        repeat (2) @(negedge clk);
        #3;
        i_Rst = 1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || mCount != 0 || txBusy) && n < 3000) begin
            idle(1);
            n++;
        end
        check("drain_timeout", 32'(n < 3000), 32'd1);
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Single byte into empty FIFO, idle transmitter: launch 2 cycles on.
        do_reset();
        idle(2);
        drive(1, 8'h41, 0);
        drive(0, 8'h00, 0);
        check("lat_fTx_early", {31'd0, o_fTx}, 32'd0);
        check("lat_count1", 32'(o_Count), 32'd1);
        drive(0, 8'h00, 0);
        check("lat_fTx", {31'd0, o_fTx}, 32'd1);
        check("lat_data", {24'd0, o_TxData}, 32'h41);
        check("lat_count0", 32'(o_Count), 32'd0);
        drain();

        // Fill with transmitter held off, then overflow.
        do_reset();
        hold = 1;
        idle(2);
        for (int i = 0; i < 16; i++) drive(1, 8'(i), 0);
        drive(1, 8'hAA, 0);
        drive(0, 8'h00, 0);
        check("fill_full", {31'd0, o_fFull}, 32'd1);
        check("fill_count", 32'(o_Count), 32'd16);
        check("fill_ovf", {31'd0, o_fOvf}, 32'd1);
        // Write while full in the launch cycle.
        hold = 0;
        drive(1, 8'h55, 0);
        drive(0, 8'h00, 0);
        check("wrfull_count", 32'(o_Count), 32'd16);
        check("wrfull_fTx", {31'd0, o_fTx}, 32'd1);
        check("wrfull_head", {24'd0, o_TxData}, 32'h00);
        drain();
        drive(0, 8'h00, 1);
        idle(1);
        check("ovf_cleared", {31'd0, o_fOvf}, 32'd0);

        // Three bytes through the transmitter model.
        do_reset();
        bitTime = 1;
        idle(1);
        nLaunch = 0;
        for (int i = 0; i < 3; i++) drive(1, 8'(8'hC0 + i), 0);
        drain();
        check("three_launches", 32'(nLaunch), 32'd3);

        // Reset while busy with 5 queued.
        for (int i = 0; i < 6; i++) drive(1, 8'(8'h70 + i), 0);
        idle(5);
        check("pre_rst_busy", {31'd0, o_fBusy}, 32'd1);
        check("pre_rst_count", 32'(o_Count), 32'd5);
        do_reset();
        nLaunch = 0;
        idle(30);
        check("post_rst_no_launch", 32'(nLaunch), 32'd0);
        drive(1, 8'h99, 0);
        drain();
        check("post_rst_launch", 32'(nLaunch), 32'd1);

        // Randomised traffic.
        randBits = 1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) hold = !hold;
            drive(($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 39) == 0));
        end
        hold = 0;
        drain();
        randBits = 0;
        bitTime = 1;

`ifdef UART_TX_FIFO_OVF_CNT_EN
        do_reset();
        hold = 1;
        idle(2);
        for (int i = 0; i < 300; i++) drive(1, 8'(i), 0);
        idle(1);
        check("ovfcnt_sat", {24'd0, o_OvfCnt}, 32'd255);
        drive(0, 8'h00, 1);
        idle(1);
        check("ovfcnt_clr", {24'd0, o_OvfCnt}, 32'd0);
        check("ovfcnt_ovf_clr", {31'd0, o_fOvf}, 32'd0);
        hold = 0;
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO depth in bytes (power of two, 2..256).
REQ-002 SHALL have parameter AW, default 4, pointer width (log2 DEPTH).
REQ-003 SHALL have port i_Clk  input  1  clock, rising edge.
REQ-004 SHALL have port i_Rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_fWr  input  1  write strobe, one byte per high cycle.
REQ-006 SHALL have port i_WrData  input  8  byte to enqueue.
REQ-007 SHALL have port i_fClrOvf  input  1  synchronous clear of overflow status.
REQ-008 SHALL have port i_fTxReady  input  1  transmitter idle (transmitter ready flag).
REQ-009 SHALL have port i_fTxDone  input  1  transmitter stop-bit-complete pulse.
REQ-010 SHALL have port o_fTx  output  1  registered one-cycle launch pulse to transmitter.
REQ-011 SHALL have port o_TxData  output  8  registered byte, stable from launch until next launch.
REQ-012 SHALL have port o_fFull  output  1  count == DEPTH.
REQ-013 SHALL have port o_fEmpty  output  1  count == 0.
REQ-014 SHALL have port o_Count  output  AW+1  bytes stored, 0..DEPTH.
REQ-015 SHALL have port o_fOvf  output  1  sticky: a write was dropped.
REQ-016 SHALL have port o_fBusy  output  1  launch state machine not in IDLE.

Function
REQ-017 SHALL store bytes in DEPTH-entry circular buffer; read/write pointers AW bits, wrap DEPTH-1 -> 0.
REQ-018 SHALL enqueue i_WrData on i_fWr when not full; data readable at head one cycle later.
REQ-019 SHALL drop write when full and no pop that cycle; set o_fOvf next cycle; buffer unchanged.
REQ-020 SHALL accept write when full if pop occurs same cycle; count unchanged.
REQ-021 SHALL on simultaneous write and pop when empty: no pop (nothing to pop), write accepted, count 1.
REQ-022 SHALL implement state machine IDLE, LAUNCH, BUSY.
REQ-023 IDLE: if i_fTxReady=1 and count>0 -> o_fTx=1 one cycle, o_TxData=head byte, pointer/count pop, go LAUNCH; else stay.
REQ-024 LAUNCH: o_fTx=0; i_fTxReady=0 -> BUSY; else stay.
REQ-025 BUSY: i_fTxDone=1 -> IDLE; else stay.
REQ-026 SHALL give launch latency of 2 cycles from accepted write into empty FIFO (idle transmitter) to o_fTx high.
REQ-027 SHALL, back-to-back, launch next byte the cycle after transmitter returns to ready (one-cycle gap minimum).
REQ-028 i_fClrOvf SHALL clear o_fOvf; if a drop occurs same cycle, o_fOvf stays 1 (set wins).
REQ-029 o_fFull, o_fEmpty, o_Count SHALL reflect registered count, no combinational path from i_fWr.

Reset
REQ-030 On i_Rst=0 SHALL immediately set state IDLE, pointers 0, count 0, o_fTx=0, o_TxData=8'hFF, o_fOvf=0.
REQ-031 Reset outputs: o_fEmpty=1, o_fFull=0, o_Count=0, o_fBusy=0; buffer contents not reset.
REQ-032 Reset mid-transfer SHALL discard all queued bytes; no o_fTx until new write after release.

Configuration
REQ-033 Macro UART_TX_FIFO_OVF_CNT_EN defined: SHALL add port o_OvfCnt output 8, saturating (stops at 255) count of dropped writes, reset 0, cleared by i_fClrOvf (increment wins over clear).
REQ-034 Macro undefined: o_OvfCnt port and counter absent; all other behaviour identical.

Verification
REQ-035 Reset, write 8'h41 into empty FIFO, i_fTxReady=1 -> o_fTx pulse 2 cycles later with o_TxData=8'h41, o_Count 1->0.
REQ-036 Write 16 bytes 8'h00..8'h0F with transmitter busy -> o_fFull=1, o_Count=16; 17th write 8'hAA dropped, o_fOvf=1; drained order 00..0F.
REQ-037 Full FIFO, write 8'h55 same cycle as launch -> count stays 16, 8'h55 transmitted 16th after launched byte.
REQ-038 Model transmitter (ready low 1 cycle after o_fTx, done pulse after 10 bit times) with 3 queued bytes -> exactly 3 o_fTx pulses, each after prior i_fTxDone, none while BUSY.
REQ-039 Assert i_Rst=0 in BUSY with 5 queued -> o_fEmpty=1, o_fBusy=0 immediately; no o_fTx after release until new write.
REQ-040 With UART_TX_FIFO_OVF_CNT_EN: 300 writes to full FIFO -> o_OvfCnt=255; i_fClrOvf -> o_OvfCnt=0, o_fOvf=0.
